sap_core: RTL and testbench

Parametrised successor to the SAP-1 top level: a single-clock accumulator processor with internal program/data RAM, a load mode for programming the RAM, and an execute mode that runs a multi-cycle fetch/execute state machine. It extends the SAP-1 instruction set (LDA, ADD, SUB, OUT, HLT) with STA, LDI, JMP, JC and JZ, plus carry/zero flags and an output-valid strobe. It generalises data and address widths, and sits at the top of the SAP design in place of the fixed 8-bit/16-word machine.

---
 rtl/sap_pkg.sv | 53 +++++
 rtl/sap_ram.sv | 32 +++
 rtl/sap_core.sv | 177 +++++++++++++++++
 tb/tb_sap_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap_pkg
// Description : Shared opcodes, FSM state encoding and the flag-producing
//               add/subtract helper for the SAP accumulator processor.
// Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

    // Opcode field values (top four bits of the instruction word)
    localparam logic [3:0] c_OP_LDA = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_STA = 4'b0100;
    localparam logic [3:0] c_OP_LDI = 4'b0101;
    localparam logic [3:0] c_OP_JMP = 4'b0110;
    localparam logic [3:0] c_OP_JC  = 4'b0111;
    localparam logic [3:0] c_OP_JZ  = 4'b1000;
    localparam logic [3:0] c_OP_OUT = 4'b1110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    // Explicitly encoded fetch/execute states
    localparam int c_ST_W = 3;
    typedef enum logic [c_ST_W-1:0] {
        ST_T1   = 3'd0,
        ST_T2   = 3'd1,
        ST_T3   = 3'd2,
        ST_T4   = 3'd3,
        ST_T5   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // Widest data path the helper supports; callers zero-extend into it
    localparam int c_ALU_W = 32;
    localparam logic [c_ALU_W:0] c_ALU_ONE = (c_ALU_W+1)'(1);

    // Returns {carry, sum} of a +/- b over 'width' bits, carry at bit 'width'.
    // Subtraction is a + ~b + 1, so carry=1 means no borrow.
    function automatic logic [c_ALU_W:0] alu_addsub(
        input logic [c_ALU_W-1:0] a,
        input logic [c_ALU_W-1:0] b,
        input logic               sub,
        input int unsigned        width
    );
        logic [c_ALU_W:0] mask;
        logic [c_ALU_W:0] b_eff;
        mask  = (c_ALU_ONE << width) - c_ALU_ONE;
        b_eff = sub ? (~{1'b0, b} & mask) : {1'b0, b};
        return {1'b0, a} + b_eff + {{c_ALU_W{1'b0}}, sub};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sap_ram.sv
`default_nettype none
// ============================================================================
// Module      : sap_ram
// Description : Program/data RAM, one synchronous write port and one
//               combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Write port commits on the rising edge
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sap_core.sv
`default_nettype none
// ============================================================================
// Module      : sap_core
// Description : Parametrised SAP accumulator processor: load mode programs the
//               internal RAM, execute mode runs a T1..T5 fetch/execute FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              n_clr,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              flag_c,
    output logic              flag_z
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_halted;
    logic              r_c;
    logic              r_z;

    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_ram_rd;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [c_ALU_W:0]  w_alu_full;
    logic [DATA_W:0]   w_sum;
    logic [c_ALU_W-DATA_W-1:0] w_alu_unused_hi;

    assign w_op      = r_ir[DATA_W-1 -: 4];
    assign w_operand = r_ir[ADDR_W-1:0];
    assign w_imm     = DATA_W'(r_ir[DATA_W-5:0]);

    assign w_alu_full      = alu_addsub(c_ALU_W'(r_acc), c_ALU_W'(r_b),
                                        (w_op == c_OP_SUB), DATA_W);
    assign w_sum           = w_alu_full[DATA_W:0];
    assign w_alu_unused_hi = w_alu_full[c_ALU_W:DATA_W+1];

    // RAM write port: programming interface in load mode, STA during execute
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = prog_addr;
        w_ram_wdata = prog_data;
        if (!run) begin
            w_ram_we = prog_we;
        end else begin
            w_ram_we    = (r_state == ST_T4) && (w_op == c_OP_STA);
            w_ram_waddr = r_mar;
            w_ram_wdata = r_acc;
        end
    end

    sap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (r_mar),
        .o_rdata (w_ram_rd)
    );

    // Fetch/execute FSM with registered architectural state and outputs
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            r_state     <= ST_T1;
            r_pc        <= '0;
            r_mar       <= '0;
            r_ir        <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (!run) begin
                // Load mode abandons any instruction in flight
                r_state  <= ST_T1;
                r_pc     <= '0;
                r_mar    <= '0;
                r_ir     <= '0;
                r_b      <= '0;
                r_halted <= 1'b0;
            end else begin
                case (r_state)
                    ST_T1: begin
                        r_mar   <= r_pc;
                        r_state <= ST_T2;
                    end
                    ST_T2: begin
                        r_ir    <= w_ram_rd;
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= ST_T3;
                    end
                    ST_T3: begin
                        r_state <= ST_T1;
                        case (w_op)
                            c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                                r_mar   <= w_operand;
                                r_state <= ST_T4;
                            end
                            c_OP_LDI: r_acc <= w_imm;
                            c_OP_JMP: r_pc  <= w_operand;
                            c_OP_JC:  if (r_c) r_pc <= w_operand;
                            c_OP_JZ:  if (r_z) r_pc <= w_operand;
                            c_OP_OUT: begin
                                r_out_data  <= r_acc;
                                r_out_valid <= 1'b1;
                            end
                            c_OP_HLT: begin
                                r_state  <= ST_HALT;
                                r_halted <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    ST_T4: begin
                        r_state <= ST_T1;
                        case (w_op)
                            c_OP_LDA: r_acc <= w_ram_rd;
                            c_OP_ADD, c_OP_SUB: begin
                                r_b     <= w_ram_rd;
                                r_state <= ST_T5;
                            end
                            default: ;
                        endcase
                    end
                    ST_T5: begin
                        r_acc   <= w_sum[DATA_W-1:0];
                        r_c     <= w_sum[DATA_W];
                        r_z     <= (w_sum[DATA_W-1:0] == '0);
                        r_state <= ST_T1;
                    end
                    ST_HALT: r_state <= ST_HALT;
                    default: r_state <= ST_T1;
                endcase
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign halted    = r_halted;
    assign pc        = r_pc;
    assign acc       = r_acc;
    assign flag_c    = r_c;
    assign flag_z    = r_z;

endmodule
`default_nettype wire

// File: tb/tb_sap_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap_core
// Description : Directed self-checking bench for sap_core (8/4 default build
//               plus a 12/8 wide build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_clr, run, prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] out_data, acc;
    logic [3:0] pc;
    logic       out_valid, halted, flag_c, flag_z;

    logic        run_w, prog_we_w;
    logic [7:0]  prog_addr_w, pc_w;
    logic [11:0] prog_data_w, out_data_w, acc_w;
    logic        out_valid_w, halted_w, flag_c_w, flag_z_w;

    int total = 0;
    int bad   = 0;
    int cyc, pulses, first_ov;

    sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .n_clr(n_clr), .run(run), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .out_data(out_data),
        .out_valid(out_valid), .halted(halted), .pc(pc), .acc(acc),
        .flag_c(flag_c), .flag_z(flag_z)
    );

    sap_core #(.DATA_W(12), .ADDR_W(8)) dut_w (
        .clk(clk), .n_clr(n_clr), .run(run_w), .prog_we(prog_we_w),
        .prog_addr(prog_addr_w), .prog_data(prog_data_w), .out_data(out_data_w),
        .out_valid(out_valid_w), .halted(halted_w), .pc(pc_w), .acc(acc_w),
        .flag_c(flag_c_w), .flag_z(flag_z_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic load_w(input logic [7:0] a, input logic [11:0] d);
        prog_we_w = 1'b1; prog_addr_w = a; prog_data_w = d;
        tick();
        prog_we_w = 1'b0;
    endtask

    // Raise run and count edges until halted, noting out_valid pulses
    task automatic run_prog(input int budget);
        cyc = 0; pulses = 0; first_ov = 0;
        run = 1'b1;
        while (halted !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
            if (out_valid === 1'b1) begin
                pulses++;
                if (first_ov == 0) first_ov = cyc;
            end
        end
        chk("halt_reached", halted, 1);
    endtask

    task automatic stop_run();
        run = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_clr = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        run_w = 1'b0; prog_we_w = 1'b0; prog_addr_w = '0; prog_data_w = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_acc", acc, 0);
        chk("rst_flag_c", flag_c, 0);
        chk("rst_flag_z", flag_z, 0);
        #2 n_clr = 1'b1;
        tick();

        // SAP-1 program: 0x10 + 0x14 - 0x18 = 0x0C
        load(4'h0, 8'h09); load(4'h1, 8'h1A); load(4'h2, 8'h2B);
        load(4'h3, 8'hE0); load(4'h4, 8'hF0);
        load(4'h9, 8'h10); load(4'hA, 8'h14); load(4'hB, 8'h18);
        run_prog(60);
        chk("sap1_out_data", out_data, 8'h0C);
        chk("sap1_pulses", pulses, 1);
        chk("sap1_out_edge", first_ov, 17);      // 4+5+5+3 edges
        chk("sap1_halt_edge", cyc, 20);          // plus 3 for HLT
        chk("sap1_flag_c", flag_c, 1);
        chk("sap1_flag_z", flag_z, 0);
        chk("sap1_pc", pc, 5);
        tick(); tick();
        chk("sap1_halt_hold", halted, 1);
        chk("sap1_ov_low", out_valid, 0);
        stop_run();
        chk("load_mode_unhalt", halted, 0);

        // Carry/wrap: 0xF0 + 0x20
        load(4'h0, 8'h08); load(4'h1, 8'h19); load(4'h2, 8'hF0);
        load(4'h8, 8'hF0); load(4'h9, 8'h20);
        run_prog(60);
        chk("add_wrap_acc", acc, 8'h10);
        chk("add_wrap_c", flag_c, 1);
        chk("add_wrap_z", flag_z, 0);
        chk("add_cycles", cyc, 12);
        stop_run();
        // SUB equal: 0xF0 - 0xF0
        load(4'h1, 8'h28);
        run_prog(60);
        chk("sub_eq_acc", acc, 8'h00);
        chk("sub_eq_c", flag_c, 1);
        chk("sub_eq_z", flag_z, 1);
        stop_run();

        // Countdown loop: LDI 3; SUB one; JZ 4; JMP 1; OUT; HLT
        load(4'h0, 8'h53); load(4'h1, 8'h27); load(4'h2, 8'h84);
        load(4'h3, 8'h61); load(4'h4, 8'hE0); load(4'h5, 8'hF0);
        load(4'h7, 8'h01);
        run_prog(120);
        chk("loop_out_data", out_data, 8'h00);
        chk("loop_pulses", pulses, 1);
        chk("loop_cycles", cyc, 39);
        chk("loop_z", flag_z, 1);
        stop_run();

        // STA/LDA round trip at the top address
        load(4'h0, 8'h59); load(4'h1, 8'h4F); load(4'h2, 8'h50);
        load(4'h3, 8'h0F); load(4'h4, 8'hE0); load(4'h5, 8'hF0);
        run_prog(60);
        chk("sta_lda_out", out_data, 8'h09);
        chk("sta_lda_acc", acc, 8'h09);
        chk("sta_lda_cycles", cyc, 20);
        stop_run();

        // PC wrap: JMP E; E: LDA D (0xE0); F: STA 0; wrap to 0 -> OUT; HLT
        load(4'h0, 8'h6E); load(4'h1, 8'hF0); load(4'hD, 8'hE0);
        load(4'hE, 8'h0D); load(4'hF, 8'h40);
        run_prog(60);
        chk("wrap_out_data", out_data, 8'hE0);
        chk("wrap_pulses", pulses, 1);
        chk("wrap_pc", pc, 2);
        chk("wrap_cycles", cyc, 17);
        stop_run();

        // Async reset during T4 of ADD
        load(4'h0, 8'h09); load(4'h1, 8'h1A); load(4'h2, 8'hF0);
        load(4'h9, 8'h10); load(4'hA, 8'h14);
        run = 1'b1;
        repeat (7) tick();
        chk("pre_rst_acc", acc, 8'h10);
        chk("pre_rst_pc", pc, 2);
        #2 n_clr = 1'b0;
        #1;
        chk("arst_out_data", out_data, 0);
        chk("arst_acc", acc, 0);
        chk("arst_pc", pc, 0);
        chk("arst_flag_c", flag_c, 0);
        chk("arst_flag_z", flag_z, 0);
        chk("arst_halted", halted, 0);
        #2 n_clr = 1'b1;
        stop_run();

        // run dropped during STA's T4: no store, PC cleared, ACC kept
        load(4'h0, 8'h56); load(4'h1, 8'h48); load(4'h2, 8'hF0);
        load(4'h8, 8'h33);
        run = 1'b1;
        repeat (6) tick();
        chk("mid_pc_before", pc, 2);
        stop_run();
        chk("mid_pc_cleared", pc, 0);
        chk("mid_acc_kept", acc, 8'h06);
        load(4'h0, 8'h08); load(4'h1, 8'hE0); load(4'h2, 8'hF0);
        // prog_we while running must be ignored
        prog_we = 1'b1; prog_addr = 4'h8; prog_data = 8'h77;
        run_prog(60);
        prog_we = 1'b0;
        chk("abandon_sta_out", out_data, 8'h33);
        chk("abandon_pulses", pulses, 1);
        stop_run();

        // Wide build: 0x7FF + 0x801 = 0x000 C=1 Z=1, then JZ 5, JMP 0xC8
        load_w(8'h00, 12'h010); load_w(8'h01, 12'h111);
        load_w(8'h02, 12'h805); load_w(8'h03, 12'hF00);
        load_w(8'h05, 12'h6C8); load_w(8'hC8, 12'hE00);
        load_w(8'hC9, 12'hF00);
        load_w(8'h10, 12'h7FF); load_w(8'h11, 12'h801);
        cyc = 0; pulses = 0;
        run_w = 1'b1;
        while (halted_w !== 1'b1 && cyc < 80) begin
            tick();
            cyc++;
            if (out_valid_w === 1'b1) pulses++;
        end
        chk("w_halt_reached", halted_w, 1);
        chk("w_acc", acc_w, 12'h000);
        chk("w_flag_c", flag_c_w, 1);
        chk("w_flag_z", flag_z_w, 1);
        chk("w_pc", pc_w, 8'hCA);
        chk("w_pulses", pulses, 1);
        chk("w_cycles", cyc, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
